// File: rtl/cdb_arbiter_if.sv
// cdb_pkg and cdb_arbiter_if
//
// cdb_pkg holds the common data bus types that the reservation stations and
// the ROB share. cdb_arbiter_if bundles the per-source result handshakes, the
// flush request and the registered bus into one port.
//
// Interface signals (named from the arbiter's point of view):
//   flush_i     pipeline flush request from the ROB
//   src_vld_i   per-source result valid
//   src_rdy_o   per-source ready; a transfer happens on vld && rdy at posedge
//   src_rob_i   per-source destination ROB index
//   src_data_i  per-source 32-bit result value
//   cdb_o       common data bus: fls plus NUM_CDB_INPUTS registered lanes
// Modports: master = functional units / ROB side, slave = the arbiter.

package cdb_pkg;

  localparam int ROB_IDX_LEN    = 5;
  localparam int NUM_CDB_INPUTS = 2;

  typedef struct packed {
    logic                   valid;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
    logic [31:0]            data;
  } cdb_lane_t;

  typedef struct packed {
    logic                                fls;
    cdb_lane_t [NUM_CDB_INPUTS-1:0]      data_lanes;
  } common_data_bus_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_SOURCES = 4
);
  import cdb_pkg::*;

  logic                                     flush_i;
  logic [NUM_SOURCES-1:0]                   src_vld_i;
  logic [NUM_SOURCES-1:0]                   src_rdy_o;
  logic [NUM_SOURCES-1:0][ROB_IDX_LEN-1:0]  src_rob_i;
  logic [NUM_SOURCES-1:0][31:0]             src_data_i;
  common_data_bus_t                         cdb_o;

  modport master (
    output flush_i, src_vld_i, src_rob_i, src_data_i,
    input  src_rdy_o, cdb_o
  );

  modport slave (
    input  flush_i, src_vld_i, src_rob_i, src_data_i,
    output src_rdy_o, cdb_o
  );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Transmit side of the common data bus. Each functional unit hands its
// completed result (ROB index + value) over a valid/ready handshake into a
// small per-source circular FIFO. Every cycle up to NUM_LANES non-empty
// sources are granted round-robin, starting at rr_ptr; the k-th granted source
// drives lane k of the registered bus. The arbiter also owns the bus flush bit:
// a flush empties every FIFO and shows fls=1 with all lanes invalid for one
// cycle per flush cycle.
//
// Parameters:
//   NUM_SOURCES  number of result producers
//   NUM_LANES    number of CDB lanes driven (<= NUM_SOURCES, <= NUM_CDB_INPUTS)
//   FIFO_DEPTH   entries per source FIFO (>= 1)
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   cdb_arbiter_if.slave (flush_i, src_* handshakes, cdb_o)
//
// Optional feature macro: CDB_BYPASS_EN. When defined, a source with an empty
// FIFO that hands over a result competes in the same cycle's grant with its
// input data, and if granted the result goes straight onto cdb_o without being
// buffered.

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int NUM_LANES   = NUM_CDB_INPUTS,
  parameter int FIFO_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int LCNT_W = $clog2(NUM_LANES + 1);

  logic [ROB_IDX_LEN-1:0] fifo_rob_q  [NUM_SOURCES][FIFO_DEPTH];
  logic [31:0]            fifo_data_q [NUM_SOURCES][FIFO_DEPTH];
  logic [PTR_W-1:0]       head_q      [NUM_SOURCES];
  logic [PTR_W-1:0]       tail_q      [NUM_SOURCES];
  logic [CNT_W-1:0]       count_q     [NUM_SOURCES];
  logic [SRC_W-1:0]       rr_ptr_q;
  common_data_bus_t       cdb_q;

  logic [NUM_SOURCES-1:0] rdy;
  logic [NUM_SOURCES-1:0] hs;
  logic [NUM_SOURCES-1:0] nonempty;
  logic [NUM_SOURCES-1:0] cand;
  logic [NUM_SOURCES-1:0] grant;
  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] pop;
  logic                   lane_vld  [NUM_LANES];
  logic [ROB_IDX_LEN-1:0] lane_rob  [NUM_LANES];
  logic [31:0]            lane_data [NUM_LANES];
  logic [SRC_W-1:0]       rr_nxt;
  logic [LCNT_W-1:0]      n_used;
  logic [SRC_W-1:0]       last_src;
  logic [SRC_W-1:0]       idx;

  // Ready looks only at the registered count (before any pop this cycle) and
  // the flush request, so a full FIFO refuses a push even while it is popping.
  always_comb begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      rdy[s]      = (count_q[s] < CNT_W'(FIFO_DEPTH)) && !bus.flush_i;
      hs[s]       = bus.src_vld_i[s] && rdy[s];
      nonempty[s] = (count_q[s] != '0);
`ifdef CDB_BYPASS_EN
      cand[s]     = nonempty[s] || hs[s];
`else
      cand[s]     = nonempty[s];
`endif
    end
  end

  assign bus.src_rdy_o = rdy;
  assign bus.cdb_o     = cdb_q;

  // Round-robin scan starting at rr_ptr: the first NUM_LANES candidates are
  // granted in scan order, so lane k carries the k-th granted source. A
  // candidate with an empty FIFO can only be a bypass, so its lane takes the
  // input data instead of the FIFO head.
  always_comb begin
    grant    = '0;
    n_used   = '0;
    last_src = '0;
    idx      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_vld[k]  = 1'b0;
      lane_rob[k]  = '0;
      lane_data[k] = '0;
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      idx = SRC_W'((int'(rr_ptr_q) + i) % NUM_SOURCES);
      if (cand[idx] && (n_used < LCNT_W'(NUM_LANES))) begin
        grant[idx]                     = 1'b1;
        lane_vld[n_used[LANE_W-1:0]]   = 1'b1;
        if (nonempty[idx]) begin
          lane_rob[n_used[LANE_W-1:0]]  = fifo_rob_q[idx][head_q[idx]];
          lane_data[n_used[LANE_W-1:0]] = fifo_data_q[idx][head_q[idx]];
        end else begin
          lane_rob[n_used[LANE_W-1:0]]  = bus.src_rob_i[idx];
          lane_data[n_used[LANE_W-1:0]] = bus.src_data_i[idx];
        end
        n_used   = n_used + LCNT_W'(1);
        last_src = idx;
      end
    end
    rr_nxt = rr_ptr_q;
    if (n_used != '0) begin
      rr_nxt = (last_src == SRC_W'(NUM_SOURCES - 1)) ? '0 : last_src + SRC_W'(1);
    end
  end

  // A granted non-empty FIFO pops its head; an accepted result is buffered
  // unless it was granted directly as a bypass.
  always_comb begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      pop[s]  = grant[s] && nonempty[s];
      push[s] = hs[s] && !(grant[s] && !nonempty[s]);
    end
  end

  // Control state and the output register. Reset beats flush, and flush beats
  // any grant computed this cycle, so buffered results are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SOURCES; s++) begin
        head_q[s]  <= '0;
        tail_q[s]  <= '0;
        count_q[s] <= '0;
      end
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else if (bus.flush_i) begin
      for (int s = 0; s < NUM_SOURCES; s++) begin
        head_q[s]  <= '0;
        tail_q[s]  <= '0;
        count_q[s] <= '0;
      end
      rr_ptr_q  <= '0;
      cdb_q.fls <= 1'b1;
      for (int k = 0; k < NUM_LANES; k++) begin
        cdb_q.data_lanes[k].valid <= 1'b0;
      end
    end else begin
      rr_ptr_q  <= rr_nxt;
      cdb_q.fls <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        cdb_q.data_lanes[k].valid <= lane_vld[k];
        if (lane_vld[k]) begin
          cdb_q.data_lanes[k].ROB_dest <= lane_rob[k];
          cdb_q.data_lanes[k].data     <= lane_data[k];
        end
      end
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (pop[s]) begin
          head_q[s] <= (head_q[s] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : head_q[s] + PTR_W'(1);
        end
        if (push[s]) begin
          tail_q[s] <= (tail_q[s] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : tail_q[s] + PTR_W'(1);
        end
        count_q[s] <= count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // FIFO storage needs no reset; the counts decide what is live.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (push[s]) begin
        fifo_rob_q[s][tail_q[s]]  <= bus.src_rob_i[s];
        fifo_data_q[s][tail_q[s]] <= bus.src_data_i[s];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter (NUM_SOURCES=4, NUM_LANES=2,
// FIFO_DEPTH=2). Every accepted result is pushed onto the expected queue of
// its source; a monitor pops and compares each valid lane that appears on the
// bus, so per-source order and exactly-once delivery are covered throughout.
// Directed checks cover reset, latency, lane placement, round-robin order,
// flush and reset during traffic. Honours CDB_BYPASS_EN for the latency.

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NSRC = 4;
`ifdef CDB_BYPASS_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 2;
`endif

  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob;
    logic [31:0]            data;
  } sb_t;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.NUM_SOURCES(NSRC)) bus ();

  cdb_arbiter #(
    .NUM_SOURCES(NSRC),
    .NUM_LANES  (2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  sb_t                    expQ [NSRC][$];
  int                     robOwner [2**ROB_IDX_LEN];
  logic [ROB_IDX_LEN-1:0] stimRob  [NSRC];
  logic [31:0]            stimData [NSRC];
  logic [NSRC-1:0]        acc;
  logic [NSRC-1:0]        lastRdy;
  logic [ROB_IDX_LEN-1:0] seenRob [$];
  int                     starve [NSRC];
  int                     maxStarve = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  // Drives one cycle of inputs at the current negedge, records which
  // handshakes will complete at the next posedge, then returns at the
  // following negedge.
  task automatic applyStimulus(input logic [NSRC-1:0] vld, input logic flush, input logic rstIn);
    bus.src_vld_i = vld;
    bus.flush_i   = flush;
    rst           = rstIn;
    for (int s = 0; s < NSRC; s++) begin
      bus.src_rob_i[s]  = stimRob[s];
      bus.src_data_i[s] = stimData[s];
    end
    #1;
    lastRdy = bus.src_rdy_o;
    acc     = rstIn ? '0 : (vld & bus.src_rdy_o);
    if (flush || rstIn) begin
      for (int s = 0; s < NSRC; s++) expQ[s].delete();
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (acc[s]) begin
          expQ[s].push_back('{rob: stimRob[s], data: stimData[s]});
          robOwner[stimRob[s]] = s;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every valid lane must be the oldest outstanding
  // result of the source that produced that ROB index.
  always @(negedge clk) begin : monitor
    logic [NSRC-1:0] served;
    sb_t             front;
    int              s;
    served = '0;
    for (int k = 0; k < 2; k++) begin
      if (bus.cdb_o.data_lanes[k].valid === 1'b1) begin
        s = robOwner[bus.cdb_o.data_lanes[k].ROB_dest];
        seenRob.push_back(bus.cdb_o.data_lanes[k].ROB_dest);
        if (expQ[s].size() == 0) begin
          checkOutput("sb_unexpected", {bus.cdb_o.data_lanes[k]}, 64'd0);
        end else begin
          front = expQ[s].pop_front();
          checkOutput("sb_lane", {bus.cdb_o.data_lanes[k].ROB_dest, bus.cdb_o.data_lanes[k].data}, front);
          served[s] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (served[i] || expQ[i].size() == 0) starve[i] = 0;
      else starve[i]++;
      if (starve[i] > maxStarve) maxStarve = starve[i];
    end
  end

  initial begin
    int robs3 [3];
    int idx3;
    int cnt [NSRC];

    rst           = 1'b1;
    bus.flush_i   = 1'b0;
    bus.src_vld_i = '0;
    for (int s = 0; s < NSRC; s++) begin
      stimRob[s]  = '0;
      stimData[s] = '0;
      cnt[s]      = 0;
      starve[s]   = 0;
    end
    for (int r = 0; r < 2**ROB_IDX_LEN; r++) robOwner[r] = 0;
    bus.src_rob_i  = '0;
    bus.src_data_i = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_fls",   bus.cdb_o.fls, 1'b0);
    checkOutput("rst_lane0", bus.cdb_o.data_lanes[0], 64'd0);
    checkOutput("rst_lane1", bus.cdb_o.data_lanes[1], 64'd0);
    checkOutput("rst_rdy",   bus.src_rdy_o, 4'hF);
    idle(1);

    // Single result from source 0
    stimRob[0]  = 5'd5;
    stimData[0] = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) applyStimulus(4'b0001, 1'b0, 1'b0);
      else idle(1);
      checkOutput($sformatf("t1_c%0d_vld0", c), bus.cdb_o.data_lanes[0].valid, (c == Lat));
      checkOutput($sformatf("t1_c%0d_vld1", c), bus.cdb_o.data_lanes[1].valid, 1'b0);
      if (c == Lat) checkOutput("t1_lane0", bus.cdb_o.data_lanes[0], {1'b1, 5'd5, 32'hDEADBEEF});
    end

    // Flush with three buffered entries
    for (int s = 0; s < 3; s++) begin
      stimRob[s]  = ROB_IDX_LEN'(10 + s);
      stimData[s] = 32'hF1000000 + 32'(s);
    end
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("fl_rdy_before", lastRdy, 4'hF);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("fl_rdy_low", lastRdy, 4'h0);
    checkOutput("fl_fls",  bus.cdb_o.fls, 1'b1);
    checkOutput("fl_vld0", bus.cdb_o.data_lanes[0].valid, 1'b0);
    checkOutput("fl_vld1", bus.cdb_o.data_lanes[1].valid, 1'b0);
    idle(1);
    checkOutput("fl_rdy_after", lastRdy, 4'hF);
    checkOutput("fl_fls_off", bus.cdb_o.fls, 1'b0);
    idle(2);

    // Back-to-back flush
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("bb_fls1", bus.cdb_o.fls, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("bb_fls2", bus.cdb_o.fls, 1'b1);
    idle(1);
    checkOutput("bb_fls3", bus.cdb_o.fls, 1'b0);

    // Four sources with one entry each, rr_ptr at 0 after the flush
    for (int s = 0; s < NSRC; s++) begin
      stimRob[s]  = ROB_IDX_LEN'(s + 1);
      stimData[s] = 32'hA0000000 + 32'(s + 1);
    end
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) applyStimulus(4'b1111, 1'b0, 1'b0);
      else idle(1);
      checkOutput($sformatf("rr_c%0d_vld0", c), bus.cdb_o.data_lanes[0].valid, (c == Lat) || (c == Lat + 1));
      checkOutput($sformatf("rr_c%0d_vld1", c), bus.cdb_o.data_lanes[1].valid, (c == Lat) || (c == Lat + 1));
      if (c == Lat) begin
        checkOutput("rr_a_lane0", bus.cdb_o.data_lanes[0], {1'b1, 5'd1, 32'hA0000001});
        checkOutput("rr_a_lane1", bus.cdb_o.data_lanes[1], {1'b1, 5'd2, 32'hA0000002});
      end
      if (c == Lat + 1) begin
        checkOutput("rr_b_lane0", bus.cdb_o.data_lanes[0], {1'b1, 5'd3, 32'hA0000003});
        checkOutput("rr_b_lane1", bus.cdb_o.data_lanes[1], {1'b1, 5'd4, 32'hA0000004});
      end
    end

    // rr_ptr back at 0: source 0 must take lane 0 ahead of source 3
    stimRob[0] = 5'd20; stimData[0] = 32'hB0000000;
    stimRob[3] = 5'd23; stimData[3] = 32'hB0000003;
    for (int c = 1; c <= 2; c++) begin
      if (c == 1) applyStimulus(4'b1001, 1'b0, 1'b0);
      else idle(1);
      if (c == Lat) begin
        checkOutput("rr0_lane0", bus.cdb_o.data_lanes[0], {1'b1, 5'd20, 32'hB0000000});
        checkOutput("rr0_lane1", bus.cdb_o.data_lanes[1], {1'b1, 5'd23, 32'hB0000003});
      end
    end
    idle(2);

    // Source 2 sends rob 7, 8, 9 back to back; broadcast order must match
    seenRob.delete();
    robs3 = '{7, 8, 9};
    idx3  = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx3 < 3) begin
        stimRob[2]  = ROB_IDX_LEN'(robs3[idx3]);
        stimData[2] = 32'hC0000000 + 32'(robs3[idx3]);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        if (acc[2]) idx3++;
      end else begin
        idle(1);
      end
    end
    checkOutput("ord_accepted", idx3, 3);
    checkOutput("ord_count", seenRob.size(), 3);
    if (seenRob.size() == 3) begin
      checkOutput("ord_first",  seenRob[0], 5'd7);
      checkOutput("ord_second", seenRob[1], 5'd8);
      checkOutput("ord_third",  seenRob[2], 5'd9);
    end

    // Sustained traffic from sources 0..2: nobody starves, all drain
    maxStarve = 0;
    for (int n = 0; n < 15; n++) begin
      for (int s = 0; s < 3; s++) begin
        stimRob[s]  = ROB_IDX_LEN'(s * 8 + (cnt[s] % 8));
        stimData[s] = $urandom;
      end
      applyStimulus(4'b0111, 1'b0, 1'b0);
      for (int s = 0; s < 3; s++) if (acc[s]) cnt[s]++;
    end
    idle(5);
    checkOutput("fair_starve", (maxStarve <= NSRC), 1'b1);
    for (int s = 0; s < NSRC; s++) begin
      checkOutput($sformatf("drain_q%0d", s), expQ[s].size(), 0);
    end

    // Reset while entries are buffered and flush is requested
    for (int s = 0; s < NSRC; s++) begin
      stimRob[s]  = ROB_IDX_LEN'(24 + s);
      stimData[s] = 32'hE0000000 + 32'(s);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("rmid_fls",   bus.cdb_o.fls, 1'b0);
    checkOutput("rmid_lane0", bus.cdb_o.data_lanes[0], 64'd0);
    checkOutput("rmid_lane1", bus.cdb_o.data_lanes[1], 64'd0);
    idle(1);
    checkOutput("rmid_rdy", lastRdy, 4'hF);
    idle(4);
    for (int s = 0; s < NSRC; s++) begin
      checkOutput($sformatf("final_q%0d", s), expQ[s].size(), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
